// File: rtl/mux_tristate_reg_tri_buf.sv
// Tri-state buffer. It drives `in` onto `out` while `oe` is high and
// releases `out` to high-Z otherwise. Several instances may share one net.
module tri_buf #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             oe,
  output wire  [WIDTH-1:0] out
);

  // Drive the shared net only while enabled.
  assign out = oe ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/mux_tristate_reg.sv
// 2:1 mux built from two tri-state drivers on a shared net. The output is
// combinational. A clocked shadow register adds a registered copy of the
// output and a saturating count of select transitions.
module mux_tristate_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_q,
  output logic [CNT_W-1:0] sel_toggles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             oe_a;
  logic             oe_b;
  wire  [WIDTH-1:0] bus;

  logic [WIDTH-1:0] dout_q_reg;
  logic             sel_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Enable decode: exactly one driver owns the net for a defined select.
  assign oe_a = ~sel;
  assign oe_b = sel;

  tri_buf #(.WIDTH(WIDTH)) u_drv_a (
    .in  (a),
    .oe  (oe_a),
    .out (bus)
  );

  tri_buf #(.WIDTH(WIDTH)) u_drv_b (
    .in  (b),
    .oe  (oe_b),
    .out (bus)
  );

  // The net goes straight out; reset never touches this path.
  assign dout = bus;

  // Saturating increment when the select differs from last edge's sample.
  always_comb begin
    cnt_next = cnt_reg;
    if ((sel != sel_d_reg) && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // Shadow registers: output copy, select history and toggle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q_reg <= '0;
      sel_d_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      dout_q_reg <= dout;
      sel_d_reg  <= sel;
      cnt_reg    <= cnt_next;
    end
  end

  assign dout_q      = dout_q_reg;
  assign sel_toggles = cnt_reg;

endmodule

// File: tb/tb_mux_tristate_reg.sv
// Bench for mux_tristate_reg: combinational truth table with the clock
// stopped, then clocked sequences checked against a scoreboard model.
`timescale 1ns/1ps
module tb_mux_tristate_reg;

  logic       clk = 1'b0;
  logic       run_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sel = 1'b0;
  logic [7:0] dout, dout_q;
  logic [7:0] sel_toggles;

  logic       a1, b1;
  logic       dout1, dout_q1;
  logic [1:0] sel_toggles1;

  assign a1 = a[0];
  assign b1 = b[0];

  int tests_run = 0;
  int tests_failed = 0;

  // Wide instance with the default 8-bit counter.
  mux_tristate_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .dout(dout), .dout_q(dout_q), .sel_toggles(sel_toggles)
  );

  // Single-bit instance with a 2-bit counter to reach saturation quickly.
  mux_tristate_reg #(.WIDTH(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel),
    .dout(dout1), .dout_q(dout_q1), .sel_toggles(sel_toggles1)
  );

  initial begin
    forever begin
      #5;
      if (run_clk) clk = ~clk;
    end
  end

  typedef struct {
    logic b;
    logic a;
    logic sel;
    logic exp;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] cnt;
    logic       q1;
    logic [1:0] cnt1;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic       m_sel_d = 1'b0;
  logic [7:0] m_cnt = '0;
  logic [1:0] m_cnt1 = '0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clocked transaction. Inputs change at the falling edge; optional
  // glitch pulses sel high and back low inside the period.
  task automatic cycle(input logic r, input logic [7:0] av, input logic [7:0] bv,
                       input logic s, input logic glitch);
    exp_t e;
    logic [7:0] mux_exp;
    @(negedge clk);
    rst = r; a = av; b = bv; sel = s;
    mux_exp = s ? bv : av;
    e.q  = r ? 8'h00 : mux_exp;
    e.q1 = r ? 1'b0 : mux_exp[0];
    if (r) begin
      m_sel_d = 1'b0; m_cnt = '0; m_cnt1 = '0;
    end else begin
      if (s != m_sel_d) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (m_cnt1 != 2'd3) m_cnt1 = m_cnt1 + 2'd1;
      end
      m_sel_d = s;
    end
    e.cnt = m_cnt;
    e.cnt1 = m_cnt1;
    sb.push_back(e);
    #1;
    check8("comb_dout", dout, mux_exp);
    if (glitch) begin
      sel = ~s;
      #1;
      check8("glitch_dout", dout, s ? av : bv);
      sel = s;
      #1;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check8("dout_q", dout_q, e.q);
    check8("sel_toggles", sel_toggles, e.cnt);
    check8("dout_q_w1", {7'd0, dout_q1}, {7'd0, e.q1});
    check8("sel_toggles_c2", {6'd0, sel_toggles1}, {6'd0, e.cnt1});
    $display("[TB] rst=%0b a=%h b=%h sel=%0b glitch=%0b -> dout_q=%h toggles=%0d toggles_c2=%0d",
             r, av, bv, s, glitch, dout_q, sel_toggles, sel_toggles1);
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{b: 1'b0, a: 1'b0, sel: 1'b0, exp: 1'b0};
    tbl[1] = '{b: 1'b1, a: 1'b0, sel: 1'b0, exp: 1'b0};
    tbl[2] = '{b: 1'b1, a: 1'b0, sel: 1'b1, exp: 1'b1};
    tbl[3] = '{b: 1'b0, a: 1'b1, sel: 1'b1, exp: 1'b0};
    tbl[4] = '{b: 1'b0, a: 1'b1, sel: 1'b0, exp: 1'b1};

    // Combinational truth table, clock stopped, each vector held 1 us.
    for (int i = 0; i < 5; i++) begin
      a = {7'd0, tbl[i].a};
      b = {7'd0, tbl[i].b};
      sel = tbl[i].sel;
      #1000;
      check8("tt_dout_w1", {7'd0, dout1}, {7'd0, tbl[i].exp});
      $display("[TB] tt b=%0b a=%0b sel=%0b -> dout=%0b", tbl[i].b, tbl[i].a, tbl[i].sel, dout1);
    end

    // Wide vectors, still no clock.
    a = 8'hA5; b = 8'h3C; sel = 1'b0; #10;
    check8("wide_sel0", dout, 8'hA5);
    sel = 1'b1; #10;
    check8("wide_sel1", dout, 8'h3C);
    $display("[TB] wide a=a5 b=3c -> dout=%h", dout);

    // Clocked section: two reset cycles, then release with a=1, sel=0.
    sel = 1'b0;
    run_clk = 1'b1;
    cycle(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);

    // Toggle sel each cycle five times from 0.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h11 + 8'(i), 8'hE0 + 8'(i), (i % 2 == 0), 1'b0);
    end
    check8("toggles_after5", sel_toggles, 8'd5);

    // Hold, then one more toggle back to 0 (sixth), then a 0->1->0 glitch.
    cycle(1'b0, 8'h22, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h01, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h01, 8'h77, 1'b0, 1'b1);
    check8("toggles_glitch", sel_toggles, 8'd6);
    check8("sat_c2", {6'd0, sel_toggles1}, 8'd3);
    cycle(1'b0, 8'h01, 8'h77, 1'b0, 1'b0);

    // Reset mid-run while dout_q=1 and small counter saturated.
    check8("pre_rst_q", {7'd0, dout_q1}, 8'd1);
    cycle(1'b1, 8'h01, 8'h5A, 1'b1, 1'b0);
    cycle(1'b1, 8'hC3, 8'h5A, 1'b0, 1'b0);

    // Release with sel=1: first edge counts one toggle.
    cycle(1'b0, 8'hC3, 8'h5A, 1'b1, 1'b0);
    check8("post_rst_cnt", sel_toggles, 8'd1);
    cycle(1'b0, 8'hC3, 8'h5A, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
